any1_div_fu: RTL

- Iterative integer divide functional unit: the consumer side of the sALUrec issue interface and the producer side of the sFuncUnit result interface.
- The reorder buffer writes divide instructions into a small input queue.
- The unit runs a radix-2 restoring divide, one quotient bit per clock, then presents the result to the ROB and holds it until acknowledged.

---
 rtl/any1_pkg.sv | 83 ++++++++
 rtl/any1_fu_fifo.sv | 74 +++++++
 rtl/any1_div_fu.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/any1_pkg.sv
// Shared types and constants for the any1 functional units.
package any1_pkg;

    localparam int AWID = 64;

    localparam logic [6:0] OP_R2     = 7'h02;
    localparam logic [6:0] OP_DIVI   = 7'h40;
    localparam logic [6:0] OP_DIVUI  = 7'h41;
    localparam logic [6:0] OP_DIVSUI = 7'h42;

    localparam logic [5:0] FN_DIV    = 6'h20;
    localparam logic [5:0] FN_DIVU   = 6'h21;
    localparam logic [5:0] FN_DIVSU  = 6'h22;

    parameter logic [7:0] FLT_UNIMP = 8'h37;
    parameter logic [7:0] FLT_DBZ   = 8'h3A;

    typedef struct packed {
        logic [5:0]  func;
        logic [18:0] rsv;
    } sR2;

    typedef struct packed {
        sR2         r2;
        logic [6:0] opcode;
    } sInstr;

    typedef struct packed {
        logic            wr;
        logic [4:0]      rid;
        sInstr           ir;
        logic [AWID-1:0] a;
        logic [AWID-1:0] b;
        logic [AWID-1:0] imm;
    } sALUrec;

    typedef struct packed {
        logic            cmt;
        logic [4:0]      rid;
        logic [2:0]      ele;
        logic [AWID-1:0] res;
        logic [7:0]      cause;
        logic [AWID-1:0] badAddr;
    } sFuncUnit;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIV1 = 3'd1,
        DIV2 = 3'd2,
        DIV3 = 3'd3,
        DIV4 = 3'd4
    } e_div_state;

    typedef struct packed {
        logic valid;
        logic use_imm;
        logic a_signed;
        logic b_signed;
    } s_div_dec;

    // Classify a divide instruction: operand source and signedness.
    function automatic s_div_dec div_decode(input logic [6:0] opcode, input logic [5:0] func);
        s_div_dec d;
        d = '0;
        if (opcode == OP_R2) begin
            case (func)
                FN_DIV:   begin d.valid = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
                FN_DIVU:  begin d.valid = 1'b1; end
                FN_DIVSU: begin d.valid = 1'b1; d.a_signed = 1'b1; end
                default:  d = '0;
            endcase
        end else begin
            case (opcode)
                OP_DIVI:   begin d.valid = 1'b1; d.use_imm = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
                OP_DIVUI:  begin d.valid = 1'b1; d.use_imm = 1'b1; end
                OP_DIVSUI: begin d.valid = 1'b1; d.use_imm = 1'b1; d.a_signed = 1'b1; end
                default:   d = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/any1_fu_fifo.sv
// Small synchronous FIFO of issue records shared by the iterative units.
// The head is read asynchronously so a unit can pop and latch in one cycle.
module any1_fu_fifo
    import any1_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      clear,
    input  logic                      wr,
    input  logic                      rd,
    input  sALUrec                    din,
    output sALUrec                    dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(QDEPTH):0]   count
);
    localparam int PW = $clog2(QDEPTH);

    sALUrec mem [QDEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic [PW:0]   count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr && !full_reg && !clear;
    assign do_rd = rd && !empty_reg && !clear;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop keeps it.
    always_comb begin
        count_next = count_reg;
        if (clear)
            count_next = '0;
        else
            count_next = count_reg + (PW+1)'(do_wr) - (PW+1)'(do_rd);
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_rd)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == (PW+1)'(QDEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate validity.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr_reg] <= din;
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign count = count_reg;

endmodule

// File: rtl/any1_div_fu.sv
// Iterative radix-2 restoring divide unit: queue in, one quotient bit per
// clock, result held for the ROB until acknowledged.
module any1_div_fu
    import any1_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int WID    = 64
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  sALUrec   alu_i,
    output logic     full_o,
    output logic     busy_o,
    output sFuncUnit fu_o,
    input  logic     ack_i,
    input  logic     flush_i
);
    localparam int CW  = $clog2(WID);
    localparam int QCW = $clog2(QDEPTH) + 1;

    sALUrec         q_dout;
    logic           q_full;
    logic           q_empty;
    logic [QCW-1:0] q_count;
    logic           q_wr;
    logic           q_rd;

    e_div_state     state_reg, state_next;
    logic [4:0]     rid_reg, rid_next;
    s_div_dec       dec_reg, dec_next;
    logic [WID-1:0] a_reg, a_next;
    logic [WID-1:0] dvs_reg, dvs_next;
    logic [WID-1:0] quot_reg, quot_next;
    logic [WID-1:0] rem_reg, rem_next;
    logic           neg_reg, neg_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [7:0]     cause_reg, cause_next;
    sFuncUnit       fu_reg, fu_next;

    s_div_dec       pop_dec;
    logic           a_neg;
    logic           d_neg;
    logic [WID:0]   rem_sh;
    logic [WID:0]   rem_dif;
    logic           q_bit;
    logic           unused_bits;

    assign q_wr = alu_i.wr && !flush_i;

    any1_fu_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk_i),
        .srst  (rst_i),
        .clear (flush_i),
        .wr    (q_wr),
        .rd    (q_rd),
        .din   (alu_i),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign pop_dec     = div_decode(q_dout.ir.opcode, q_dout.ir.r2.func);
    assign unused_bits = ^{q_dout.wr, q_dout.ir.r2.rsv};

    assign a_neg   = dec_reg.a_signed & a_reg[WID-1];
    assign d_neg   = dec_reg.b_signed & dvs_reg[WID-1];
    // No borrow out of the trial subtract means the shifted remainder >= divisor.
    assign rem_sh  = {rem_reg, quot_reg[WID-1]};
    assign rem_dif = rem_sh - {1'b0, dvs_reg};
    assign q_bit   = !rem_dif[WID];

    // Next-state and datapath control; flush overrides everything.
    always_comb begin
        state_next = state_reg;
        rid_next   = rid_reg;
        dec_next   = dec_reg;
        a_next     = a_reg;
        dvs_next   = dvs_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        neg_next   = neg_reg;
        cnt_next   = cnt_reg;
        cause_next = cause_reg;
        fu_next    = fu_reg;
        q_rd       = 1'b0;
        if (flush_i) begin
            state_next = IDLE;
            fu_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!q_empty) begin
                        q_rd       = 1'b1;
                        rid_next   = q_dout.rid;
                        dec_next   = pop_dec;
                        a_next     = q_dout.a;
                        dvs_next   = pop_dec.use_imm ? q_dout.imm : q_dout.b;
                        state_next = DIV1;
                    end
                end
                DIV1: begin
                    if (!dec_reg.valid) begin
                        quot_next  = '0;
                        cause_next = FLT_UNIMP;
                        state_next = DIV4;
                    end else if (dvs_reg == '0) begin
                        quot_next  = '1;
                        cause_next = FLT_DBZ;
                        state_next = DIV4;
                    end else begin
                        quot_next  = a_neg ? -a_reg : a_reg;
                        dvs_next   = d_neg ? -dvs_reg : dvs_reg;
                        neg_next   = a_neg ^ d_neg;
                        rem_next   = '0;
                        cnt_next   = '0;
                        cause_next = '0;
                        state_next = DIV2;
                    end
                end
                DIV2: begin
                    rem_next  = q_bit ? rem_dif[WID-1:0] : rem_sh[WID-1:0];
                    quot_next = {quot_reg[WID-2:0], q_bit};
                    cnt_next  = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WID-1))
                        state_next = DIV3;
                end
                DIV3: begin
                    fu_next     = '0;
                    fu_next.cmt = 1'b1;
                    fu_next.rid = rid_reg;
                    fu_next.res = neg_reg ? -quot_reg : quot_reg;
                    state_next  = DIV4;
                end
                DIV4: begin
                    // Fault results arrive here without a posted result; post it first.
                    if (!fu_reg.cmt) begin
                        fu_next       = '0;
                        fu_next.cmt   = 1'b1;
                        fu_next.rid   = rid_reg;
                        fu_next.res   = quot_reg;
                        fu_next.cause = cause_reg;
                    end else if (ack_i) begin
                        fu_next    = '0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            rid_reg   <= '0;
            dec_reg   <= '0;
            a_reg     <= '0;
            dvs_reg   <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            neg_reg   <= 1'b0;
            cnt_reg   <= '0;
            cause_reg <= '0;
            fu_reg    <= '0;
        end else begin
            state_reg <= state_next;
            rid_reg   <= rid_next;
            dec_reg   <= dec_next;
            a_reg     <= a_next;
            dvs_reg   <= dvs_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            neg_reg   <= neg_next;
            cnt_reg   <= cnt_next;
            cause_reg <= cause_next;
            fu_reg    <= fu_next;
        end
    end

    assign full_o = q_full;
    assign busy_o = (q_count != '0) || (state_reg != IDLE);
    assign fu_o   = fu_reg;

endmodule
